rpc_cmd_decoder: RTL

- Device-side decoder for the RPC DRAM command channel, used in the DRAM behavioural/FPGA model and in loopback test harnesses.
- Receives 32-bit command packets as two 16-bit beats and validates them.
- Decodes each packet into the team's decoded command codes: CMD_INVALID=0, RESET=1, PRE=2, MRS=3, ACT=4, WR=5, RD=6, REF=7, ZQC=8; ZQC modes ZQINIT=0, ZQCL=1, ZQCS=2, ZQRESET=3.
- Presents decoded fields on a valid/ready output with a single holding register.

---
 rtl/rpc_cmd_decoder.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/rpc_cmd_decoder.sv
// RPC DRAM command-channel decoder: assembles two 16-bit beats into a
// 32-bit packet, validates parity/reserved/opcode, and presents decoded
// fields through a single valid/ready holding register.
// Ports: clk_i, rst_ni (sync, active low); beat_valid_i/beat_ready_o/
// beat_data_i (input beats, low half first); cmd_valid_o/cmd_ready_i and
// cmd_type_o, cmd_bank_o, cmd_addr_o, cmd_len_o, cmd_zqc_o, cmd_err_o
// (decoded command); timeout_o (partial packet dropped).
// Optional macro RPC_CMD_DEC_STATS_EN adds cnt_ok_o, cnt_err_o and
// cnt_timeout_o saturating counters of CNT_W bits.
module rpc_cmd_decoder #(
  parameter int unsigned TIMEOUT = 16
`ifdef RPC_CMD_DEC_STATS_EN
  ,
  parameter int unsigned CNT_W = 16
`endif
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        beat_valid_i,
  output logic        beat_ready_o,
  input  logic [15:0] beat_data_i,
  output logic        cmd_valid_o,
  input  logic        cmd_ready_i,
  output logic [3:0]  cmd_type_o,
  output logic [1:0]  cmd_bank_o,
  output logic [12:0] cmd_addr_o,
  output logic [5:0]  cmd_len_o,
  output logic [1:0]  cmd_zqc_o,
  output logic [1:0]  cmd_err_o,
  output logic        timeout_o
`ifdef RPC_CMD_DEC_STATS_EN
  ,
  output logic [CNT_W-1:0] cnt_ok_o,
  output logic [CNT_W-1:0] cnt_err_o,
  output logic [CNT_W-1:0] cnt_timeout_o
`endif
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  localparam logic [3:0] CMD_INVALID = 4'd0;
  localparam logic [3:0] CMD_WR      = 4'd5;
  localparam logic [3:0] CMD_RD      = 4'd6;
  localparam logic [3:0] CMD_ZQC     = 4'd8;

  typedef enum logic {
    IDLE,
    WAIT_B1
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] lo_q, lo_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic        tmo_q, tmo_d;
  logic        vld_q, vld_d;
  logic [3:0]  type_q, type_d;
  logic [1:0]  bank_q, bank_d;
  logic [12:0] addr_q, addr_d;
  logic [5:0]  len_q, len_d;
  logic [1:0]  zqc_q, zqc_d;
  logic [1:0]  err_q, err_d;

  logic        beat_rdy;
  logic        xfer;
  logic        ld;
  logic [31:0] word;
  logic [3:0]  op;
  logic        par_bad;
  logic        rsv_bad;
  logic        op_bad;
  logic [1:0]  dec_err;

  assign beat_rdy = rst_ni && (!vld_q || cmd_ready_i);
  assign xfer     = beat_valid_i && beat_rdy;

  assign word    = {beat_data_i, lo_q};
  assign op      = word[3:0];
  assign par_bad = ~^word;
  assign rsv_bad = |word[30:27];
  assign op_bad  = (op == 4'd0) || (op > CMD_ZQC);

  always_comb begin
    dec_err = 2'd0;
    priority case (1'b1)
      par_bad: dec_err = 2'd1;
      rsv_bad: dec_err = 2'd2;
      op_bad:  dec_err = 2'd3;
      default: dec_err = 2'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    tmo_d   = 1'b0;
    ld      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (xfer) begin
          lo_d    = beat_data_i;
          cnt_d   = '0;
          state_d = WAIT_B1;
        end
      end
      WAIT_B1: begin
        if (xfer) begin
          ld      = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == TW'(TIMEOUT - 1)) begin
          tmo_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    vld_d  = vld_q && !cmd_ready_i;
    type_d = type_q;
    bank_d = bank_q;
    addr_d = addr_q;
    len_d  = len_q;
    zqc_d  = zqc_q;
    err_d  = err_q;
    if (ld) begin
      vld_d  = 1'b1;
      err_d  = dec_err;
      type_d = CMD_INVALID;
      bank_d = '0;
      addr_d = '0;
      len_d  = '0;
      zqc_d  = '0;
      if (dec_err == 2'd0) begin
        type_d = op;
        bank_d = word[7:6];
        addr_d = word[20:8];
        if (op == CMD_WR || op == CMD_RD) begin
          len_d = word[26:21];
        end
        if (op == CMD_ZQC) begin
          zqc_d = word[5:4];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      lo_q    <= '0;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
      vld_q   <= 1'b0;
      type_q  <= '0;
      bank_q  <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      zqc_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      vld_q   <= vld_d;
      type_q  <= type_d;
      bank_q  <= bank_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      zqc_q   <= zqc_d;
      err_q   <= err_d;
    end
  end

  assign beat_ready_o = beat_rdy;
  assign cmd_valid_o  = vld_q;
  assign cmd_type_o   = type_q;
  assign cmd_bank_o   = bank_q;
  assign cmd_addr_o   = addr_q;
  assign cmd_len_o    = len_q;
  assign cmd_zqc_o    = zqc_q;
  assign cmd_err_o    = err_q;
  assign timeout_o    = tmo_q;

`ifdef RPC_CMD_DEC_STATS_EN
  logic [CNT_W-1:0] ok_q, ok_d;
  logic [CNT_W-1:0] bad_q, bad_d;
  logic [CNT_W-1:0] to_q, to_d;

  always_comb begin
    ok_d  = ok_q;
    bad_d = bad_q;
    to_d  = to_q;
    if (ld && dec_err == 2'd0 && ok_q != '1) begin
      ok_d = ok_q + 1'b1;
    end
    if (ld && dec_err != 2'd0 && bad_q != '1) begin
      bad_d = bad_q + 1'b1;
    end
    if (tmo_d && to_q != '1) begin
      to_d = to_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ok_q  <= '0;
      bad_q <= '0;
      to_q  <= '0;
    end else begin
      ok_q  <= ok_d;
      bad_q <= bad_d;
      to_q  <= to_d;
    end
  end

  assign cnt_ok_o      = ok_q;
  assign cnt_err_o     = bad_q;
  assign cnt_timeout_o = to_q;
`endif

endmodule
